trig_conditioner: RTL

//  Upstream conditioning stage for the timestamp counter's capture strobe.

---
 rtl/trig_conditioner_pkg.sv | 17 +
 rtl/trig_conditioner_sync.sv | 33 +++
 rtl/trig_conditioner.sv | 117 +++++++++++
 3 files changed

// File: rtl/trig_conditioner_pkg.sv
// rtl/trig_conditioner_pkg.sv - shared types and constants for the trigger conditioner
package trig_conditioner_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == SAT_MAX) ? SAT_MAX : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/trig_conditioner_sync.sv
// rtl/trig_conditioner_sync.sv - async input synchronizer with rising-edge detect
module sync_edge_detect #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  // Edges are masked until the pipeline has refilled after reset, so a level
  // held high through reset is not mistaken for a fresh rising edge.
  assign rise  = level & ~prev_q & fill_q[SYNC_STAGES];

endmodule

// File: rtl/trig_conditioner.sv
// rtl/trig_conditioner.sv - trigger conditioning FSM with holdoff, period and timeout stats
module trig_conditioner
  import trig_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int HOLD_W      = 16,
  parameter int TIMEOUT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_in,
  input  logic              enable,
  input  logic [HOLD_W-1:0] holdoff,
  output logic              trig_pulse,
  output logic              trig_level,
  output logic [CNT_W-1:0]  accept_count,
  output logic [CNT_W-1:0]  reject_count,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  output logic              timeout
);

  localparam logic [CNT_W:0] TO_THR = (CNT_W+1)'(TIMEOUT);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  acc_d, rej_d, period_d;
  logic              pulse_d, pv_d, to_d;
  logic              rise, timeout_hit;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (trig_in),
    .level   (trig_level),
    .rise    (rise)
  );

  // Widened compare so a saturated gap cannot wrap into a false match.
  assign timeout_hit = (TIMEOUT != 0) && (({1'b0, gap_q} + (CNT_W+1)'(1)) == TO_THR);

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    gap_d    = gap_q;
    first_d  = first_q;
    acc_d    = accept_count;
    rej_d    = reject_count;
    period_d = period;
    pulse_d  = 1'b0;
    pv_d     = 1'b0;
    to_d     = timeout;
    if (!enable) begin
      state_d = ST_IDLE;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
          gap_d   = '0;
          first_d = 1'b1;
        end
        ST_ARMED, ST_HOLDOFF: begin
          gap_d = sat_inc(gap_q);
          if (state_q == ST_HOLDOFF) begin
            hcnt_d = hcnt_q - HOLD_W'(1);
            if (hcnt_q == HOLD_W'(1)) state_d = ST_ARMED;
            if (rise) rej_d = reject_count + CNT_W'(1);
          end else if (rise) begin
            pulse_d = 1'b1;
            acc_d   = accept_count + CNT_W'(1);
            hcnt_d  = holdoff;
            gap_d   = '0;
            first_d = 1'b0;
            to_d    = 1'b0;
            if (!first_q) begin
              period_d = sat_inc(gap_q);
              pv_d     = 1'b1;
            end
            state_d = (holdoff == '0) ? ST_ARMED : ST_HOLDOFF;
          end
          if (!pulse_d && timeout_hit) to_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      gap_q        <= '0;
      first_q      <= 1'b1;
      accept_count <= '0;
      reject_count <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      trig_pulse   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      gap_q        <= gap_d;
      first_q      <= first_d;
      accept_count <= acc_d;
      reject_count <= rej_d;
      period       <= period_d;
      period_valid <= pv_d;
      trig_pulse   <= pulse_d;
      timeout      <= to_d;
    end
  end

endmodule
